// File: rtl/ifu_lsu_mem_arb.sv
// rtl/ifu_lsu_mem_arb.sv - single-port SRAM arbiter between instruction fetch and load/store
// Optional round-robin arbitration enabled by defining MEM_ARB_RR_EN.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE `XLEN
`endif

module ifu_lsu_mem_arb (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [`PC_SIZE-1:0]   ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [`INSTR_SIZE-1:0] ifu_rsp_instr,
    input  logic                  ifu_flush,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [`PC_SIZE-1:0]   lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [`XLEN-1:0]      lsu_req_wdata,
    input  logic [3:0]            lsu_req_wmask,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [`XLEN-1:0]      lsu_rsp_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [`PC_SIZE-3:0]   mem_addr,
    output logic [`XLEN-1:0]      mem_wdata,
    output logic [3:0]            mem_wem,
    input  logic [`XLEN-1:0]      mem_rdata
);

    typedef enum logic {S_IDLE, S_PEND} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [`XLEN-1:0] hold_q, hold_d;
    logic             first_q, first_d;
    logic             wr_q, wr_d;
    logic             rsp_valid, rsp_hs, slot, lsu_pri, lsu_win, ifu_win;
    logic [`XLEN-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
    owner_e           rr_q, rr_d;
`endif

    // Byte offsets are irrelevant to a word-addressed SRAM.
    logic unused_lsbs;
    assign unused_lsbs = ^{ifu_req_pc[1:0], lsu_req_addr[1:0]};

    always_comb begin
        // A flush hides the IFU response in the same cycle it is raised.
        rsp_valid     = (state_q == S_PEND) && !((owner_q == OWN_IFU) && ifu_flush);
        ifu_rsp_valid = rsp_valid && (owner_q == OWN_IFU);
        lsu_rsp_valid = rsp_valid && (owner_q == OWN_LSU);
        rsp_hs        = (ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready);
        slot          = rst_n && ((state_q == S_IDLE) || rsp_hs);

`ifdef MEM_ARB_RR_EN
        lsu_pri = !ifu_req_valid || (rr_q == OWN_IFU);
`else
        lsu_pri = 1'b1;
`endif
        lsu_win = slot && lsu_req_valid && lsu_pri;
        ifu_win = slot && ifu_req_valid && !lsu_win;

        lsu_req_ready = lsu_win;
        ifu_req_ready = ifu_win;
        mem_cs        = lsu_win || ifu_win;
        mem_we        = lsu_win && lsu_req_wen;
        mem_wem       = (lsu_win && lsu_req_wen) ? lsu_req_wmask : 4'b0000;
        mem_wdata     = lsu_win ? lsu_req_wdata : '0;
        mem_addr      = lsu_win ? lsu_req_addr[`PC_SIZE-1:2] : ifu_req_pc[`PC_SIZE-1:2];

        rsp_data      = first_q ? mem_rdata : hold_q;
        ifu_rsp_instr = rsp_data;
        lsu_rsp_rdata = wr_q ? '0 : rsp_data;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        first_d = 1'b0;
        wr_d    = wr_q;
`ifdef MEM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        if (first_q && !wr_q) begin
            hold_d = mem_rdata;
        end
        if (mem_cs) begin
            state_d = S_PEND;
            owner_d = lsu_win ? OWN_LSU : OWN_IFU;
            first_d = 1'b1;
            wr_d    = lsu_win && lsu_req_wen;
`ifdef MEM_ARB_RR_EN
            rr_d    = lsu_win ? OWN_LSU : OWN_IFU;
`endif
        end else if (rsp_hs || ((state_q == S_PEND) && (owner_q == OWN_IFU) && ifu_flush)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            hold_q  <= '0;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q    <= OWN_IFU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            wr_q    <= wr_d;
`ifdef MEM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifu_lsu_mem_arb.sv
// tb/tb_ifu_lsu_mem_arb.sv - directed self-checking bench for ifu_lsu_mem_arb

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE `XLEN
`endif

module tb_ifu_lsu_mem_arb;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ifu_req_valid, ifu_req_ready;
    logic [`PC_SIZE-1:0]    ifu_req_pc;
    logic                   ifu_rsp_valid, ifu_rsp_ready;
    logic [`INSTR_SIZE-1:0] ifu_rsp_instr;
    logic                   ifu_flush;
    logic                   lsu_req_valid, lsu_req_ready;
    logic [`PC_SIZE-1:0]    lsu_req_addr;
    logic                   lsu_req_wen;
    logic [`XLEN-1:0]       lsu_req_wdata;
    logic [3:0]             lsu_req_wmask;
    logic                   lsu_rsp_valid, lsu_rsp_ready;
    logic [`XLEN-1:0]       lsu_rsp_rdata;
    logic                   mem_cs, mem_we;
    logic [`PC_SIZE-3:0]    mem_addr;
    logic [`XLEN-1:0]       mem_wdata;
    logic [3:0]             mem_wem;
    logic [`XLEN-1:0]       mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_lsu_pattern;

    always #5 clk = ~clk;

    ifu_lsu_mem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
        .ifu_flush(ifu_flush),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wem(mem_wem), .mem_rdata(mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_lsu_pattern = 4'b0101;
`else
        exp_lsu_pattern = 4'b1111;
`endif
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h0; ifu_rsp_ready = 1'b0; ifu_flush = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; lsu_rsp_ready = 1'b0; mem_rdata = 32'h0;
        step(); #1;
        chk("reset_mem_cs", mem_cs, 1'b0);
        chk("reset_ifu_ready", ifu_req_ready, 1'b0);
        chk("reset_lsu_ready", lsu_req_ready, 1'b0);
        chk("reset_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("reset_lsu_rsp_valid", lsu_rsp_valid, 1'b0);

        // IFU-only read at pc 0x100
        step();
        rst_n = 1'b1; lsu_req_valid = 1'b0; ifu_req_pc = 32'h100; ifu_rsp_ready = 1'b1; #1;
        chk("ifu_rd_cs", mem_cs, 1'b1);
        chk("ifu_rd_ready", ifu_req_ready, 1'b1);
        chk("ifu_rd_addr", mem_addr, 30'h40);
        chk("ifu_rd_we", mem_we, 1'b0);
        chk("ifu_rd_wem", mem_wem, 4'h0);
        step();
        ifu_req_valid = 1'b0; mem_rdata = 32'h13; #1;
        chk("ifu_rd_rsp_valid", ifu_rsp_valid, 1'b1);
        chk("ifu_rd_instr", ifu_rsp_instr, 32'h13);
        chk("ifu_rd_lsu_valid", lsu_rsp_valid, 1'b0);
        step(); #1;
        chk("ifu_rd_done", ifu_rsp_valid, 1'b0);

        // Both requesting for 4 cycles
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_rsp_ready = 1'b1;
        ifu_req_pc = 32'h200; lsu_req_addr = 32'h300; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step(); #1;
            end
            chk("both_cs", mem_cs, 1'b1);
            chk("both_lsu_ready", lsu_req_ready, exp_lsu_pattern[i]);
            chk("both_ifu_ready", ifu_req_ready, !exp_lsu_pattern[i]);
        end
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; #1;
        chk("both_last_rsp", ifu_rsp_valid | lsu_rsp_valid, 1'b1);
        step(); #1;

        // LSU read with response stall; IFU keeps requesting
        lsu_req_valid = 1'b1; ifu_req_valid = 1'b1; lsu_req_addr = 32'h200;
        lsu_req_wmask = 4'hF; lsu_rsp_ready = 1'b0; ifu_rsp_ready = 1'b0; #1;
        chk("stall_grant_lsu", lsu_req_ready, 1'b1);
        chk("stall_rd_we", mem_we, 1'b0);
        chk("stall_rd_wem", mem_wem, 4'h0);
        step();
        lsu_req_valid = 1'b0; mem_rdata = 32'hDEADBEEF; #1;
        chk("stall_rdata0", lsu_rsp_rdata, 32'hDEADBEEF);
        chk("stall_cs0", mem_cs, 1'b0);
        chk("stall_ifu_ready0", ifu_req_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            mem_rdata = 32'h1111_0000 + 32'(i); #1;
            chk("stall_valid", lsu_rsp_valid, 1'b1);
            chk("stall_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
            chk("stall_cs", mem_cs, 1'b0);
        end
        step();
        lsu_rsp_ready = 1'b1; #1;
        chk("stall_rdata_hs", lsu_rsp_rdata, 32'hDEADBEEF);
        chk("stall_release_ifu_grant", ifu_req_ready, 1'b1);
        chk("stall_release_cs", mem_cs, 1'b1);
        step();
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b1; mem_rdata = 32'h55; #1;
        chk("stall_ifu_instr", ifu_rsp_instr, 32'h55);
        step(); #1;

        // LSU write
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_wmask = 4'b0011;
        lsu_req_wdata = 32'h1234; lsu_req_addr = 32'h300; #1;
        chk("wr_we", mem_we, 1'b1);
        chk("wr_wem", mem_wem, 4'b0011);
        chk("wr_wdata", mem_wdata, 32'h1234);
        chk("wr_addr", mem_addr, 30'hC0);
        step();
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; mem_rdata = 32'hFFFFFFFF; #1;
        chk("wr_rsp_valid", lsu_rsp_valid, 1'b1);
        chk("wr_rsp_rdata", lsu_rsp_rdata, 32'h0);
        step(); #1;

        // Flush of a stalled IFU response, LSU waiting
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h400; ifu_rsp_ready = 1'b0; #1;
        chk("fl_ifu_grant", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_req_addr = 32'h500; ifu_flush = 1'b1; #1;
        chk("fl_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("fl_no_cs", mem_cs, 1'b0);
        chk("fl_no_lsu_ready", lsu_req_ready, 1'b0);
        step();
        ifu_flush = 1'b0; #1;
        chk("fl_after_valid", ifu_rsp_valid, 1'b0);
        chk("fl_lsu_grant", lsu_req_ready, 1'b1);
        chk("fl_lsu_addr", mem_addr, 30'h140);
        step();
        lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
        chk("fl_lsu_rdata", lsu_rsp_rdata, 32'hA5A5A5A5);
        step(); #1;

        // Reset pulse while a response is pending
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h800; ifu_rsp_ready = 1'b0; #1;
        chk("rst_ifu_grant", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_req_addr = 32'h600; #1;
        chk("rst_pend_valid", ifu_rsp_valid, 1'b1);
        #1 rst_n = 1'b0; #1;
        chk("rst_async_ifu_valid", ifu_rsp_valid, 1'b0);
        chk("rst_async_lsu_valid", lsu_rsp_valid, 1'b0);
        chk("rst_async_cs", mem_cs, 1'b0);
        step();
        rst_n = 1'b1; #1;
        chk("rst_first_grant", lsu_req_ready, 1'b1);
        chk("rst_first_addr", mem_addr, 30'h180);
        step();
        lsu_req_valid = 1'b0; #1;
        chk("rst_new_rsp", lsu_rsp_valid, 1'b1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
